// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and constants for the UART TX arbiter.
// Holds the arbiter state encoding, the byte type, the fixed requester
// indices and a helper that advances the round-robin pointer.

package uart_tx_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   typedef logic [7:0] byte_t;

   // Fixed requester slots on the shared TX path
   localparam int REQ_BOOT  = 0;
   localparam int REQ_CORE  = 1;
   localparam int REQ_DEBUG = 2;

   // Index following idx in a ring of n requesters
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first set bit of 'valid' found by scanning upward from
// 'start' with wrap-around, plus a flag telling whether any bit was set.

module rr_pick #(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] start,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [2*N-1:0] doubled;
   logic [N-1:0]   rotated;
   logic [IW-1:0]  offset;
   logic [IW:0]    sum;

   // Rotate the request vector so that bit 0 corresponds to 'start'
   assign doubled = {valid, valid};
   assign rotated = doubled[int'(start) +: N];

   // Lowest set bit of the rotated vector is the winner's distance from start
   always_comb begin
      offset = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            offset = IW'(k);
         end
      end
   end

   assign found = |rotated;
   assign sum   = {1'b0, start} + {1'b0, offset};

   // Map the distance back to an absolute index modulo N
   assign idx = (int'(sum) >= N) ? IW'(int'(sum) - N) : sum[IW-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares the TX FIFO write port among NREQ byte producers.
// Round-robin at message granularity: a granted requester keeps the port
// until it delivers a byte flagged 'last'. FIFO 'full' is folded straight
// into the per-requester ready so backpressure costs no extra latency.
// Optional idle watchdog: define UART_TX_ARB_WATCHDOG_EN to release a lock
// whose owner stays silent for IDLE_LIMIT cycles.

module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int NREQ       = 3,
   parameter int IDLE_LIMIT = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0][7:0]    req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    full,
   output logic                    wr_en,
   output logic [7:0]              wr_data,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    timeout_err
);

   localparam int IW = $clog2(NREQ);

   arb_state_t    state_reg;
   arb_state_t    state_next;
   logic [IW-1:0] rr_ptr_reg;
   logic [IW-1:0] rr_ptr_next;
   logic [IW-1:0] grant_reg;
   logic [IW-1:0] grant_next;
   logic          locked;
   logic          xfer;
   logic          release_lock;
   logic          wd_expire;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] after_grant;
   byte_t         sel_data;

   rr_pick #(
      .N  (NREQ),
      .IW (IW)
   ) u_rr_pick (
      .valid (req_valid),
      .start (rr_ptr_reg),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign locked       = (state_reg == ARB_LOCKED);
   assign xfer         = locked & req_valid[grant_reg] & ~full;
   assign release_lock = (xfer & req_last[grant_reg]) | wd_expire;
   assign after_grant  = IW'(rr_next(int'(grant_reg), NREQ));
   assign sel_data     = req_data[grant_reg];

   // Only the granted requester may see ready, and only while the FIFO has room
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = locked & ~full & (grant_reg == IW'(gi));
      end
   endgenerate

   assign wr_en    = xfer;
   assign wr_data  = xfer ? sel_data : 8'h00;
   assign busy     = locked;
   assign grant_id = grant_reg;

   // Next-state: grab a winner in IDLE, hold the lock until message end or watchdog
   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      grant_next  = grant_reg;
      case (state_reg)
         ARB_IDLE: begin
            if (pick_found) begin
               state_next = ARB_LOCKED;
               grant_next = pick_idx;
            end
         end
         ARB_LOCKED: begin
            if (release_lock) begin
               state_next  = ARB_IDLE;
               rr_ptr_next = after_grant;
            end
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   // Arbiter state, round-robin pointer and grant registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ARB_IDLE;
         rr_ptr_reg <= '0;
         grant_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         grant_reg  <= grant_next;
      end
   end

`ifdef UART_TX_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(IDLE_LIMIT + 1);

   logic [WD_W-1:0] wd_cnt_reg;
   logic            timeout_reg;

   // Expire on the cycle that would be the IDLE_LIMIT-th silent cycle
   assign wd_expire = locked & ~req_valid[grant_reg]
                    & (wd_cnt_reg == WD_W'(IDLE_LIMIT - 1));

   // Count owner-silent cycles; stalls on 'full' with valid high do not count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt_reg <= '0;
      end else if (!locked || xfer || wd_expire) begin
         wd_cnt_reg <= '0;
      end else if (!req_valid[grant_reg]) begin
         wd_cnt_reg <= wd_cnt_reg + 1'b1;
      end
   end

   // One-cycle error pulse in the IDLE cycle that follows a forced release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_reg <= 1'b0;
      end else begin
         timeout_reg <= wd_expire;
      end
   end

   assign timeout_err = timeout_reg;
`else
   logic unused_idle_limit;

   assign wd_expire         = 1'b0;
   assign timeout_err       = 1'b0;
   assign unused_idle_limit = (IDLE_LIMIT > 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Watchdog scenario expectations follow UART_TX_ARB_WATCHDOG_EN.

module tb_uart_tx_arbiter;

   import uart_tx_arb_pkg::*;

   logic             clk;
   logic             reset;
   logic [2:0]       req_valid;
   logic [2:0][7:0]  req_data;
   logic [2:0]       req_last;
   logic [2:0]       req_ready;
   logic             full;
   logic             wr_en;
   logic [7:0]       wr_data;
   logic             busy;
   logic [1:0]       grant_id;
   logic             timeout_err;

   int n_checks;
   int n_pass;

   uart_tx_arbiter #(
      .NREQ       (3),
      .IDLE_LIMIT (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .full        (full),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .busy        (busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},    32'(busy),        32'd0);
      chk({tag, "_wr_en"},   32'(wr_en),       32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data),     32'h00);
      chk({tag, "_ready"},   32'(req_ready),   32'd0);
      chk({tag, "_grant"},   32'(grant_id),    32'd0);
      chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
   endtask

   // Assert reset asynchronously, check reset values, release on a falling edge
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      chk_reset_vals(tag);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      logic [7:0] exp_byte;
      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b0;
      full      = 1'b0;
      req_valid = 3'b111;
      req_data  = '0;
      req_last  = 3'b000;

      // Reset state while every requester is asking
      #3;
      chk_reset_vals("rst0");
      @(negedge clk);
      req_valid = 3'b000;
      reset     = 1'b1;

      // Single requester: core sends 0x48, 0x69(last)
      @(negedge clk);
      req_valid[REQ_CORE] = 1'b1;
      req_data[REQ_CORE]  = 8'h48;
      #1;
      chk("t1_idle_wr_en", 32'(wr_en), 32'd0);
      chk("t1_idle_busy",  32'(busy),  32'd0);
      @(negedge clk); #1;
      chk("t1_b0_busy",  32'(busy),      32'd1);
      chk("t1_b0_grant", 32'(grant_id),  32'd1);
      chk("t1_b0_ready", 32'(req_ready), 32'b010);
      chk("t1_b0_wr_en", 32'(wr_en),     32'd1);
      chk("t1_b0_data",  32'(wr_data),   32'h48);
      @(negedge clk);
      req_data[REQ_CORE] = 8'h69;
      req_last[REQ_CORE] = 1'b1;
      #1;
      chk("t1_b1_wr_en", 32'(wr_en),   32'd1);
      chk("t1_b1_data",  32'(wr_data), 32'h69);
      @(negedge clk);
      req_valid = 3'b000;
      req_last  = 3'b000;
      #1;
      chk("t1_end_busy",  32'(busy),     32'd0);
      chk("t1_end_wr_en", 32'(wr_en),    32'd0);
      chk("t1_end_data",  32'(wr_data),  32'h00);
      chk("t1_end_grant", 32'(grant_id), 32'd1);

      // Contention: boot and core both valid from reset, 2-byte messages
      req_valid = 3'b011;
      req_data[REQ_BOOT] = 8'hA1;
      req_data[REQ_CORE] = 8'hB1;
      do_reset("t2_rst");
      #1;
      chk("t2_idle_wr_en", 32'(wr_en), 32'd0);
      @(negedge clk); #1;
      chk("t2_a1_grant", 32'(grant_id),  32'd0);
      chk("t2_a1_ready", 32'(req_ready), 32'b001);
      chk("t2_a1_data",  32'(wr_data),   32'hA1);
      @(negedge clk);
      req_data[REQ_BOOT] = 8'hA2;
      req_last[REQ_BOOT] = 1'b1;
      #1;
      chk("t2_a2_data", 32'(wr_data), 32'hA2);
      @(negedge clk);
      req_valid[REQ_BOOT] = 1'b0;
      req_last[REQ_BOOT]  = 1'b0;
      #1;
      chk("t2_gap_busy",  32'(busy),      32'd0);
      chk("t2_gap_wr_en", 32'(wr_en),     32'd0);
      chk("t2_gap_ready", 32'(req_ready), 32'd0);
      @(negedge clk); #1;
      chk("t2_b1_grant", 32'(grant_id), 32'd1);
      chk("t2_b1_data",  32'(wr_data),  32'hB1);
      @(negedge clk);
      req_data[REQ_CORE] = 8'hB2;
      req_last[REQ_CORE] = 1'b1;
      #1;
      chk("t2_b2_data", 32'(wr_data), 32'hB2);
      @(negedge clk);
      req_valid = 3'b000;
      req_last  = 3'b000;
      #1;
      chk("t2_end_busy", 32'(busy), 32'd0);

      // Fairness: all three continuously valid with last=1
      req_valid = 3'b111;
      req_last  = 3'b111;
      req_data[REQ_BOOT]  = 8'h10;
      req_data[REQ_CORE]  = 8'h20;
      req_data[REQ_DEBUG] = 8'h30;
      do_reset("t3_rst");
      for (int i = 0; i < 6; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         chk($sformatf("t3_idle%0d_wr_en", i), 32'(wr_en), 32'd0);
         @(negedge clk); #1;
         exp_byte = 8'((i % 3 + 1) * 16);
         chk($sformatf("t3_msg%0d_grant", i), 32'(grant_id), 32'(i % 3));
         chk($sformatf("t3_msg%0d_wr_en", i), 32'(wr_en),    32'd1);
         chk($sformatf("t3_msg%0d_data", i),  32'(wr_data),  32'(exp_byte));
      end

      // Backpressure: full high for 5 cycles in the middle of a core message
      @(negedge clk);
      req_valid = 3'b000;
      req_last  = 3'b000;
      #1;
      chk("t4_pre_busy", 32'(busy), 32'd0);
      @(negedge clk);
      req_valid[REQ_CORE] = 1'b1;
      req_data[REQ_CORE]  = 8'hC1;
      #1;
      chk("t4_idle_wr_en", 32'(wr_en), 32'd0);
      @(negedge clk); #1;
      chk("t4_c1_data", 32'(wr_data), 32'hC1);
      @(negedge clk);
      req_data[REQ_CORE] = 8'hC2;
      full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk($sformatf("t4_full%0d_wr_en", k), 32'(wr_en),     32'd0);
         chk($sformatf("t4_full%0d_ready", k), 32'(req_ready), 32'd0);
         chk($sformatf("t4_full%0d_busy", k),  32'(busy),      32'd1);
         chk($sformatf("t4_full%0d_grant", k), 32'(grant_id),  32'd1);
      end
      @(negedge clk);
      full = 1'b0;
      #1;
      chk("t4_c2_wr_en", 32'(wr_en),     32'd1);
      chk("t4_c2_data",  32'(wr_data),   32'hC2);
      chk("t4_c2_ready", 32'(req_ready), 32'b010);
      @(negedge clk);
      req_data[REQ_CORE] = 8'hC3;
      req_last[REQ_CORE] = 1'b1;
      #1;
      chk("t4_c3_data", 32'(wr_data), 32'hC3);
      @(negedge clk);
      req_valid = 3'b000;
      req_last  = 3'b000;
      #1;
      chk("t4_end_busy", 32'(busy), 32'd0);

      // Reset after 1 of 3 core bytes, then debug message is served normally
      @(negedge clk);
      req_valid[REQ_CORE] = 1'b1;
      req_data[REQ_CORE]  = 8'hD1;
      #1;
      chk("t5_idle_wr_en", 32'(wr_en), 32'd0);
      @(negedge clk); #1;
      chk("t5_d1_grant", 32'(grant_id), 32'd1);
      chk("t5_d1_data",  32'(wr_data),  32'hD1);
      @(negedge clk);
      req_data[REQ_CORE]  = 8'hD2;
      req_valid            = 3'b100;
      req_data[REQ_DEBUG] = 8'h77;
      req_last[REQ_DEBUG] = 1'b1;
      do_reset("t5_rst");
      #1;
      chk("t5_post_idle_wr_en", 32'(wr_en), 32'd0);
      @(negedge clk); #1;
      chk("t5_dbg_grant", 32'(grant_id), 32'd2);
      chk("t5_dbg_wr_en", 32'(wr_en),    32'd1);
      chk("t5_dbg_data",  32'(wr_data),  32'h77);
      @(negedge clk);
      req_valid = 3'b000;
      req_last  = 3'b000;
      #1;
      chk("t5_end_busy", 32'(busy), 32'd0);

      // Watchdog: core sends one non-last byte then goes silent, debug waits
      @(negedge clk);
      req_valid[REQ_CORE] = 1'b1;
      req_data[REQ_CORE]  = 8'h55;
      #1;
      chk("t6_idle_wr_en", 32'(wr_en), 32'd0);
      @(negedge clk); #1;
      chk("t6_b0_grant", 32'(grant_id), 32'd1);
      chk("t6_b0_data",  32'(wr_data),  32'h55);
      @(negedge clk);
      req_valid            = 3'b100;
      req_data[REQ_DEBUG] = 8'h99;
      req_last[REQ_DEBUG] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k != 0) @(negedge clk);
         #1;
         chk($sformatf("t6_silent%0d_busy", k),    32'(busy),        32'd1);
         chk($sformatf("t6_silent%0d_wr_en", k),   32'(wr_en),       32'd0);
         chk($sformatf("t6_silent%0d_timeout", k), 32'(timeout_err), 32'd0);
      end
`ifdef UART_TX_ARB_WATCHDOG_EN
      @(negedge clk); #1;
      chk("t6_rel_busy",    32'(busy),        32'd0);
      chk("t6_rel_timeout", 32'(timeout_err), 32'd1);
      @(negedge clk); #1;
      chk("t6_dbg_grant",   32'(grant_id),    32'd2);
      chk("t6_dbg_wr_en",   32'(wr_en),       32'd1);
      chk("t6_dbg_data",    32'(wr_data),     32'h99);
      chk("t6_dbg_timeout", 32'(timeout_err), 32'd0);
`else
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         chk($sformatf("t6_hold%0d_busy", k),    32'(busy),        32'd1);
         chk($sformatf("t6_hold%0d_grant", k),   32'(grant_id),    32'd1);
         chk($sformatf("t6_hold%0d_wr_en", k),   32'(wr_en),       32'd0);
         chk($sformatf("t6_hold%0d_timeout", k), 32'(timeout_err), 32'd0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit FIFO write port between several byte producers (bootloader, core print path, debug/status source). Round-robin arbitration at message granularity: once granted, a requester holds the port until it delivers a byte flagged `last`, so multi-byte messages are never interleaved. Sits directly in front of the TX FIFO and absorbs FIFO backpressure into per-requester ready signals.

## Interface
- `NREQ`, 3, number of requesters (2..8); index 0 = bootloader, 1 = core, 2 = debug
- `IDLE_LIMIT`, 1024, watchdog idle-cycle limit (used only with the watchdog compiled in)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0)
- `req_valid`  in  NREQ  requester i has a byte on `req_data[i]`
- `req_data`  in  NREQ×8  byte per requester
- `req_last`  in  NREQ  byte is final byte of the message
- `req_ready`  out  NREQ  byte accepted this cycle when `req_valid[i]` also high
- `full`  in  1  TX FIFO full
- `wr_en`  out  1  TX FIFO write strobe
- `wr_data`  out  8  TX FIFO write data
- `busy`  out  1  a message is in progress (state LOCKED)
- `grant_id`  out  clog2(NREQ)  current/last granted requester
- `timeout_err`  out  1  one-cycle pulse on watchdog release

## Operation
- FSM with two states: IDLE, LOCKED.
- IDLE: if any `req_valid`, select first valid index scanning from `rr_ptr` upward with wrap; register it into `grant_id`; go LOCKED. No byte transfers in IDLE.
- LOCKED with grant g: `req_ready[g] = ~full`; all other `req_ready` = 0. Transfer occurs when `req_valid[g] & ~full`.
- `wr_en` = transfer (combinational); `wr_data = req_data[grant_id]`; 0x00 whenever `wr_en` is 0.
- Transfer with `req_last[g]` = 1: go IDLE, `rr_ptr <= (g+1) mod NREQ`.
- Single-byte producers tie `req_last` high; each byte is then a message.
- `busy` = (state == LOCKED).
- Requester dropping `req_valid` mid-message keeps the lock (no other requester served).
- `full` high: no write, no ready; state and grant held, no bytes dropped.
- Reset mid-message: immediate return to IDLE, `rr_ptr` = 0, partial message abandoned.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant_id` 0, `busy` 0, `req_ready` all 0, `wr_en` 0, `wr_data` 0x00, `timeout_err` 0, watchdog counter 0.
- Arbitration latency: valid seen in IDLE at cycle N → LOCKED at N+1 → first byte written at N+1 if `full` low.
- Within a message: one byte per cycle while valid and not full; zero added latency (ready/wr_en combinational from `full`).
- Between messages: exactly one IDLE cycle, so back-to-back messages cost length+1 cycles.
- `grant_id` changes only on the IDLE→LOCKED edge.

## Configuration
- `UART_TX_ARB_WATCHDOG_EN` defined: counter in LOCKED increments each cycle `req_valid[g]` is 0, clears on every transfer and on entering LOCKED; cycles with valid high but `full` high do not count. Reaching `IDLE_LIMIT` → go IDLE, advance `rr_ptr` past g, pulse `timeout_err` for one cycle.
- Not defined: no counter, lock held indefinitely, `timeout_err` tied 0, `IDLE_LIMIT` unused.

## Structure
- Package `uart_tx_arb_pkg`: state enum (`ARB_IDLE`, `ARB_LOCKED`), `byte_t` typedef, requester index constants (`REQ_BOOT`, `REQ_CORE`, `REQ_DEBUG`).
- Sub-module `rr_pick`: combinational round-robin selector (valid vector + start pointer → found flag + index); instanced once.

## Test plan
- Single requester: core sends 0x48,0x69(last) with `full` low → `wr_en` at cycles N+1,N+2, data 0x48,0x69; `busy` drops after 0x69.
- Contention: boot and core both valid from reset, 2-byte messages each → boot bytes first, then one IDLE cycle, then core bytes; never interleaved.
- Fairness: all three requesters continuously valid with last=1 → grant order 0,1,2,0,1,2; each byte 2 cycles apart.
- Backpressure: `full` high for 5 cycles mid-message → `wr_en` and `req_ready` 0 for those 5 cycles, next byte written cycle after `full` falls, no loss/duplication.
- Reset mid-message after 1 of 3 bytes → all outputs at reset values; subsequent message from requester 2 granted normally.
- Watchdog (macro on, `IDLE_LIMIT`=8): core sends one non-last byte then drops valid → `timeout_err` pulse after 8 idle cycles, IDLE next cycle, pending debug request granted; macro off → lock held, `timeout_err` stays 0.
